// File: rtl/scalar_wb_scheduler.sv
// Scalar register-file writeback arbiter (mem/alu/ctr) with aging promotion,
// plus the pending-write scoreboard that drives the decode RAW/WAW stall.

module scalar_wb_age #(
  parameter int AGE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic valid,
  input  logic grant,
  output logic aged
);
  logic [3:0] age;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         age <= '0;
    else if (!valid || grant)        age <= '0;
    else if (age < 4'(AGE_LIMIT))    age <= age + 4'd1;
  end

  // Gate with valid so a stale saturated count cannot win on an idle cycle.
  assign aged = valid && (age == 4'(AGE_LIMIT));
endmodule

module scalar_wb_scheduler #(
  parameter int WIDTH     = 19,
  parameter int AGE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  input  logic [4:0]       issue_rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [4:0]       rs3,
  input  logic             alu_valid,
  input  logic [4:0]       alu_rd,
  input  logic [WIDTH-1:0] alu_data,
  output logic             alu_ready,
  input  logic             mem_valid,
  input  logic [4:0]       mem_rd,
  input  logic [WIDTH-1:0] mem_data,
  output logic             mem_ready,
  input  logic             ctr_valid,
  input  logic [4:0]       ctr_rd,
  input  logic [WIDTH-1:0] ctr_data,
  output logic             ctr_ready,
  output logic             rf_wes,
  output logic [4:0]       rf_rd,
  output logic [WIDTH-1:0] rf_wd,
  output logic [31:0]      busy_mask,
  output logic             stall
);
  localparam int NUM_REQ = 3;
  // Index order is the base priority: lower index wins.
  localparam int MEM = 0;
  localparam int ALU = 1;
  localparam int CTR = 2;

  typedef struct packed {
    logic             valid;
    logic [4:0]       rd;
    logic [WIDTH-1:0] data;
  } wb_req_t;

  wb_req_t [NUM_REQ-1:0] req;
  logic    [NUM_REQ-1:0] valid_v, aged_v, cand, grant;
  logic                  grant_any;
  logic    [4:0]         sel_rd;
  logic    [WIDTH-1:0]   sel_data;
  logic    [31:0]        busy_nxt;

  assign req[MEM] = '{valid: mem_valid, rd: mem_rd, data: mem_data};
  assign req[ALU] = '{valid: alu_valid, rd: alu_rd, data: alu_data};
  assign req[CTR] = '{valid: ctr_valid, rd: ctr_rd, data: ctr_data};

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
    assign valid_v[g] = req[g].valid;
    scalar_wb_age #(.AGE_LIMIT(AGE_LIMIT)) u_age (
      .clk   (clk),
      .rst   (rst),
      .valid (valid_v[g]),
      .grant (grant[g]),
      .aged  (aged_v[g])
    );
  end

  // Aged requesters form their own class; base priority applies within a class.
  always_comb begin
    cand  = (|aged_v) ? aged_v : valid_v;
    grant = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (cand[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
      end
    end
    if (rst) grant = '0;
  end

  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_rd   = req[i].rd;
        sel_data = req[i].data;
      end
    end
  end

  assign grant_any = |grant;
  assign mem_ready = grant[MEM];
  assign alu_ready = grant[ALU];
  assign ctr_ready = grant[CTR];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_wes <= 1'b0;
      rf_rd  <= '0;
      rf_wd  <= '0;
    end else begin
      rf_wes <= grant_any && (sel_rd != 5'd0);
      if (grant_any && (sel_rd != 5'd0)) begin
        rf_rd <= sel_rd;
        rf_wd <= sel_data;
      end
    end
  end

  // Issue is applied after the clear so a new producer keeps the bit set.
  always_comb begin
    busy_nxt = busy_mask;
    if (grant_any)   busy_nxt[sel_rd]   = 1'b0;
    if (issue_valid) busy_nxt[issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_mask <= '0;
    else     busy_mask <= busy_nxt;
  end

  assign stall = busy_mask[rs1] | busy_mask[rs2] | busy_mask[rs3] |
                 (issue_valid & busy_mask[issue_rd]);
endmodule

// File: tb/tb_scalar_wb_scheduler.sv
// Directed bench: expected writes are queued when a grant is expected and
// matched against the registered write port on the following cycle.

module tb_scalar_wb_scheduler;
  localparam int WIDTH = 19;

  logic             clk = 1'b0;
  logic             rst;
  logic             issue_valid;
  logic [4:0]       issue_rd, rs1, rs2, rs3;
  logic             alu_valid, mem_valid, ctr_valid;
  logic [4:0]       alu_rd, mem_rd, ctr_rd;
  logic [WIDTH-1:0] alu_data, mem_data, ctr_data;
  logic             alu_ready, mem_ready, ctr_ready;
  logic             rf_wes;
  logic [4:0]       rf_rd;
  logic [WIDTH-1:0] rf_wd;
  logic [31:0]      busy_mask;
  logic             stall;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [4:0]       rd;
    logic [WIDTH-1:0] wd;
    int               cyc;
  } exp_t;
  exp_t q[$];

  localparam logic [2:0] NONE = 3'b000, GM = 3'b001, GA = 3'b010, GC = 3'b100;
  logic [2:0] aging_seq [11] = '{GM, GM, GM, GM, GA, GC, GM, GM, GM, GA, GC};
  logic mon_exp;

  scalar_wb_scheduler #(.WIDTH(WIDTH), .AGE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rs1(rs1), .rs2(rs2), .rs3(rs3),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .ctr_valid(ctr_valid), .ctr_rd(ctr_rd), .ctr_data(ctr_data), .ctr_ready(ctr_ready),
    .rf_wes(rf_wes), .rf_rd(rf_rd), .rf_wd(rf_wd),
    .busy_mask(busy_mask), .stall(stall)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic step(input string tag, input logic [2:0] exp_rdy, input logic exp_stall);
    #1;
    chk({tag, "_ready"}, {29'd0, ctr_ready, alu_ready, mem_ready}, {29'd0, exp_rdy});
    chk({tag, "_stall"}, {31'd0, stall}, {31'd0, exp_stall});
    if (exp_rdy[0] && mem_rd != 5'd0) q.push_back('{mem_rd, mem_data, cyc + 1});
    if (exp_rdy[1] && alu_rd != 5'd0) q.push_back('{alu_rd, alu_data, cyc + 1});
    if (exp_rdy[2] && ctr_rd != 5'd0) q.push_back('{ctr_rd, ctr_data, cyc + 1});
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon_exp = (q.size() > 0) && (q[0].cyc == cyc);
      chk("rf_wes", {31'd0, rf_wes}, {31'd0, mon_exp});
      if (mon_exp) begin
        chk("rf_rd", {27'd0, rf_rd}, {27'd0, q[0].rd});
        chk("rf_wd", {13'd0, rf_wd}, {13'd0, q[0].wd});
        void'(q.pop_front());
      end else if (q.size() > 0 && q[0].cyc < cyc) begin
        chk("wr_missing", q[0].cyc, cyc);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1;
    issue_valid = 0; issue_rd = 0; rs1 = 0; rs2 = 0; rs3 = 0;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    mem_valid = 0; mem_rd = 0; mem_data = 0;
    ctr_valid = 0; ctr_rd = 0; ctr_data = 0;
    #1;
    chk("rst_wes",  {31'd0, rf_wes}, 32'd0);
    chk("rst_rd",   {27'd0, rf_rd}, 32'd0);
    chk("rst_wd",   {13'd0, rf_wd}, 32'd0);
    chk("rst_busy", busy_mask, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single ALU write
    alu_valid = 1; alu_rd = 5; alu_data = 19'h00ABC;
    step("alu1", GA, 0);
    alu_valid = 0;
    step("alu1_idle", NONE, 0);
    step("alu1_idle2", NONE, 0);

    // Three-way contention, each drops after its grant
    mem_valid = 1; mem_rd = 2; mem_data = 19'h11111;
    alu_valid = 1; alu_rd = 1; alu_data = 19'h22222;
    ctr_valid = 1; ctr_rd = 3; ctr_data = 19'h33333;
    step("c3_mem", GM, 0);
    mem_valid = 0;
    step("c3_alu", GA, 0);
    alu_valid = 0;
    step("c3_ctr", GC, 0);
    ctr_valid = 0;
    step("c3_idle", NONE, 0);

    // Aging: mem/alu back-to-back, ctr starves until promoted
    mem_valid = 1; mem_rd = 10; mem_data = 19'h01000;
    alu_valid = 1; alu_rd = 11; alu_data = 19'h02000;
    ctr_valid = 1; ctr_rd = 7;  ctr_data = 19'h03000;
    for (int i = 0; i < 11; i++) begin
      step($sformatf("age%0d", i), aging_seq[i], 0);
      if (aging_seq[i][0]) mem_data = mem_data + 19'd1;
      if (aging_seq[i][1]) alu_data = alu_data + 19'd1;
      if (aging_seq[i][2]) ctr_data = ctr_data + 19'd1;
    end
    mem_valid = 0; alu_valid = 0; ctr_valid = 0;
    step("age_idle", NONE, 0);

    // Scoreboard and RAW stall
    issue_valid = 1; issue_rd = 9;
    step("sb_issue", NONE, 0);
    issue_valid = 0; rs2 = 9;
    chk("sb_busy9", busy_mask, 32'h0000_0200);
    step("sb_raw", NONE, 1);
    mem_valid = 1; mem_rd = 9; mem_data = 19'h00123;
    step("sb_grant", GM, 1);
    mem_valid = 0;
    step("sb_cleared", NONE, 0);
    chk("sb_busy_clr", busy_mask, 32'd0);

    // Simultaneous issue and grant to the same register
    issue_valid = 1; issue_rd = 9;
    mem_valid = 1; mem_rd = 9; mem_data = 19'h00055;
    step("sim", GM, 0);
    issue_valid = 0; mem_data = 19'h00066;
    chk("sim_busy", busy_mask, 32'h0000_0200);
    step("sim_clr", GM, 1);
    mem_valid = 0; rs2 = 0;
    chk("sim_busy_clr", busy_mask, 32'd0);

    // WAW and R0
    issue_valid = 1; issue_rd = 4;
    step("waw_set", NONE, 0);
    alu_valid = 1; alu_rd = 0; alu_data = 19'h7FFFF;
    step("waw_r0", GA, 1);
    issue_valid = 0; alu_valid = 0;
    chk("r0_busy", busy_mask, 32'h0000_0010);
    alu_valid = 1; alu_rd = 4; alu_data = 19'h00044;
    step("waw_clr", GA, 0);
    alu_valid = 0;
    chk("waw_busy_clr", busy_mask, 32'd0);

    // Asynchronous reset mid-operation
    issue_valid = 1; issue_rd = 12;
    alu_valid = 1; alu_rd = 6; alu_data = 19'h01234;
    step("rst_pre", GA, 0);
    issue_valid = 0;
    #2 rst = 1'b1;
    q.delete();
    #1;
    chk("arst_wes",   {31'd0, rf_wes}, 32'd0);
    chk("arst_busy",  busy_mask, 32'd0);
    chk("arst_ready", {31'd0, alu_ready}, 32'd0);
    @(negedge clk);
    alu_valid = 0;
    rst = 1'b0;
    step("post_rst0", NONE, 0);
    step("post_rst1", NONE, 0);
    alu_valid = 1; alu_rd = 3; alu_data = 19'h00777;
    step("post_rst_wr", GA, 0);
    alu_valid = 0;
    step("post_rst_idle", NONE, 0);
    step("post_rst_idle2", NONE, 0);
    chk("queue_drained", q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
